serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
Parallel-in, serial-out word transmitter. It is the sending end for the team's universal shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the word one bit per enabled clock on SOUT, qualified by SHIFT_EN, MSB-first or LSB-first.
- Optionally appends an even-parity bit.
- SOUT/SHIFT_EN drive a receiver's serial input and shift-enable directly.

Parameters:
WIDTH, 4, data word width; legal range is 2 or more.
PARITY, 0, 1 appends an even-parity bit after the data; frame length is WIDTH+PARITY.

Ports:
CLK  input  1  clock; all state changes on rising edge
CLRn  input  1  asynchronous active-low reset
IN_VALID  input  1  DIN/DIR are valid this cycle
IN_READY  output  1  block accepts a word this cycle
DIN  input  WIDTH  parallel word to transmit
DIR  input  1  1 = MSB-first, 0 = LSB-first; sampled with DIN
HOLD  input  1  pauses transmission while high
SOUT  output  1  current serial bit
SHIFT_EN  output  1  SOUT is valid and consumed this cycle
BUSY  output  1  frame in progress (state SHIFT)
DONE  output  1  one-cycle pulse after the last frame bit

Behaviour:
- Reset (CLRn low, asynchronous): state=IDLE, shift register=0, bit counter=0, dir_r=0, parity accumulator=0.
  - Outputs during and immediately after reset: SOUT=0, SHIFT_EN=0, BUSY=0, DONE=0, IN_READY=1.
- Handshake: a word is accepted on a rising edge where IN_VALID and IN_READY are both high. DIN and DIR are captured into internal registers.
- IN_READY is high only in IDLE and DONE.
- States:
  - IDLE: SOUT=0, SHIFT_EN=0. On accept, go to SHIFT with cnt=0 and parity=0.
  - SHIFT: BUSY=1.
    - SOUT = dir_r ? shreg[WIDTH-1] : shreg[0], while cnt < WIDTH.
    - When PARITY=1 and cnt==WIDTH, SOUT = parity accumulator, i.e. XOR of all WIDTH data bits (even parity).
    - SHIFT_EN = !HOLD.
    - On each edge with SHIFT_EN=1:
      - shreg shifts toward the output end, zero-filling the vacated bit.
      - parity ^= data bit sent.
      - cnt increments.
    - When cnt == WIDTH+PARITY-1 and SHIFT_EN=1, go to DONE.
  - DONE: DONE=1 for exactly one cycle; SOUT=0, SHIFT_EN=0.
    - On accept in this cycle, go directly to SHIFT. This gives back-to-back frames with a one-cycle gap.
    - Otherwise go to IDLE.
- Latency, no HOLD: word accepted at edge k.
  - Frame bits appear on SOUT in cycles k+1 .. k+WIDTH+PARITY.
  - DONE is high in cycle k+WIDTH+PARITY+1.
- HOLD:
  - In SHIFT: freezes shreg, cnt and parity; SOUT holds its value; SHIFT_EN=0. Each HOLD cycle delays DONE by one cycle.
  - In IDLE and DONE: ignored.
- DIN and DIR changes after acceptance have no effect on the frame in flight.
- Reset mid-frame: the frame is aborted, no DONE is produced, and the block restarts in IDLE.
- Counter width: clog2(WIDTH+2) bits. It never wraps within a legal frame.

Test Plan:
1. WIDTH=4, PARITY=0. After reset, accept DIN=4'b1000, DIR=1 at edge k.
   -> SOUT=1,0,0,0 with SHIFT_EN=1 in cycles k+1..k+4.
   -> DONE=1 only in k+5, IN_READY=1 in k+5.
2. DIN=4'b0011, DIR=0.
   -> SOUT=1,1,0,0 over 4 SHIFT_EN cycles.
   -> BUSY=1 for exactly those 4 cycles.
3. DIN=4'b1010, DIR=1, HOLD=1 during the 2nd and 3rd cycles after accept.
   -> SOUT=1, then 0 held for 3 cycles with SHIFT_EN=0,0,1, then 1, then 0.
   -> DONE in k+7.
4. IN_VALID held high with DIN=4'b1010, then 4'b0101 (DIR=1).
   -> Second word accepted in the DONE cycle of the first.
   -> SOUT=1,0,1,0 | gap | 0,1,0,1, with exactly one SHIFT_EN=0 cycle between frames.
5. PARITY=1, DIN=4'b1011, DIR=1.
   -> SOUT=1,0,1,1,1 (parity=1) over 5 cycles; DONE in k+6.
   -> With DIN=4'b0110: parity bit is 0.
6. Drive CLRn low asynchronously after 2 bits of a 4-bit frame.
   -> SOUT=0, SHIFT_EN=0, BUSY=0 immediately, no DONE pulse.
   -> IN_READY=1 after release; next word transmits normally.

Source files
------------

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-in, serial-out word transmitter with optional even parity.
// Feeds a receiver's serial input (SOUT) and shift-enable (SHIFT_EN) directly.
module serial_word_tx #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned PARITY = 0
) (
    input  logic             CLK,
    input  logic             CLRn,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIR,
    input  logic             HOLD,
    output logic             SOUT,
    output logic             SHIFT_EN,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned FRAME_LEN = WIDTH + PARITY;
    localparam int unsigned CNT_W     = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               par_q, par_d;
    logic               sout_q, sout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;

    logic               accept;
    logic               advance;
    logic               data_bit;

    assign accept   = IN_VALID && in_ready_q;
    assign advance  = (state_q == S_SHIFT) && !HOLD;
    assign data_bit = dir_q ? shreg_q[WIDTH-1] : shreg_q[0];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        par_d      = par_q;
        sout_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        in_ready_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                    shreg_d = DIN;
                    dir_d   = DIR;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            S_SHIFT: begin
                if (advance) begin
                    shreg_d = dir_q ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};
                    if (cnt_q < CNT_DATA) begin
                        par_d = par_q ^ data_bit;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d = S_SHIFT;
                    shreg_d = DIN;
                    dir_d   = DIR;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs reflect the state being entered, so they are valid right after the edge.
        busy_d     = (state_d == S_SHIFT);
        done_d     = (state_d == S_DONE);
        in_ready_d = (state_d != S_SHIFT);
        if (state_d == S_SHIFT) begin
            if (cnt_d < CNT_DATA) begin
                sout_d = dir_d ? shreg_d[WIDTH-1] : shreg_d[0];
            end else begin
                sout_d = par_d;
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            par_q      <= 1'b0;
            sout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            par_q      <= par_d;
            sout_q     <= sout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    // HOLD must gate the enable in the same cycle, so SHIFT_EN is decoded from it directly.
    assign SOUT     = sout_q;
    assign SHIFT_EN = busy_q && !HOLD;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign IN_READY = in_ready_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: two lanes (PARITY=0 and PARITY=1) with scoreboard checking.
module tb_serial_word_tx;

    localparam int W = 4;

    logic clk;
    logic clr_n;
    bit   started;
    bit   go_rst;
    bit   go_tail;
    int   checks = 0;
    int   errors = 0;

    function automatic void check(input bit ok, input string name, input int lane,
                                  input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s lane%0d: got %0d expected %0d at %0t", name, lane, act, exp, $time);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int P  = g;
        localparam int FL = W + P;

        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] din;
        logic         dir;
        logic         hold;
        logic         sout;
        logic         shift_en;
        logic         busy;
        logic         done;
        bit           at_bar;
        bit           fin;
        bit           exp_q[$];

        serial_word_tx #(.WIDTH(W), .PARITY(P)) u_dut (
            .CLK      (clk),
            .CLRn     (clr_n),
            .IN_VALID (in_valid),
            .IN_READY (in_ready),
            .DIN      (din),
            .DIR      (dir),
            .HOLD     (hold),
            .SOUT     (sout),
            .SHIFT_EN (shift_en),
            .BUSY     (busy),
            .DONE     (done)
        );

        // Reference model: the frame is the data bits in send order, then the XOR of them.
        function automatic void push_frame(input logic [W-1:0] d, input logic r);
            bit par;
            par = ^d;
            for (int i = 0; i < W; i++) exp_q.push_back(r ? d[W-1-i] : d[i]);
            if (P == 1) exp_q.push_back(par);
        endfunction

        // Monitor: compare outputs against the model away from the active edge.
        initial begin
            bit   done_due;
            bit   acc_prev;
            bit   prev_busy;
            bit   prev_en;
            logic prev_sout;
            bit   e;
            int   nbits;
            done_due = 0; acc_prev = 0; prev_busy = 0; prev_en = 0; prev_sout = 0; nbits = 0;
            forever begin
                @(negedge clk);
                if (clr_n !== 1'b1) begin
                    check(shift_en === 1'b0, "rst_hold_shift_en", g, int'(shift_en), 0);
                    check(done === 1'b0, "rst_hold_done", g, int'(done), 0);
                    check(in_ready === 1'b1, "rst_hold_in_ready", g, int'(in_ready), 1);
                    exp_q.delete();
                    done_due = 0; acc_prev = 0; prev_busy = 0; prev_en = 0; nbits = 0;
                end else begin
                    check(done === done_due, "done_timing", g, int'(done), int'(done_due));
                    if (done_due) begin
                        nbits    = 0;
                        done_due = 0;
                    end
                    check(shift_en === (busy && !hold), "shift_en_rule", g,
                          int'(shift_en), int'(busy && !hold));
                    if (busy) begin
                        check(in_ready === 1'b0, "ready_while_busy", g, int'(in_ready), 0);
                    end else begin
                        check(in_ready === 1'b1, "ready_while_idle", g, int'(in_ready), 1);
                        check(sout === 1'b0, "sout_idle", g, int'(sout), 0);
                    end
                    if (acc_prev) check(busy === 1'b1, "busy_after_accept", g, int'(busy), 1);
                    if (busy && prev_busy && !prev_en)
                        check(sout === prev_sout, "hold_sout", g, int'(sout), int'(prev_sout));
                    if (shift_en) begin
                        if (exp_q.size() == 0) begin
                            check(1'b0, "unexpected_bit", g, int'(sout), -1);
                        end else begin
                            e = exp_q.pop_front();
                            check(sout === e, "sout_bit", g, int'(sout), int'(e));
                        end
                        nbits++;
                        if (nbits == FL) done_due = 1;
                    end
                    acc_prev = in_valid && in_ready;
                    if (acc_prev) push_frame(din, dir);
                    prev_busy = busy;
                    prev_en   = shift_en;
                    prev_sout = sout;
                end
            end
        end

        // Outputs must clear the instant CLRn falls.
        initial begin
            forever begin
                @(negedge clr_n);
                #1;
                check(sout === 1'b0, "rst_sout", g, int'(sout), 0);
                check(shift_en === 1'b0, "rst_shift_en", g, int'(shift_en), 0);
                check(busy === 1'b0, "rst_busy", g, int'(busy), 0);
                check(done === 1'b0, "rst_done", g, int'(done), 0);
                check(in_ready === 1'b1, "rst_in_ready", g, int'(in_ready), 1);
            end
        end

        task automatic wait_ready();
            int n;
            n = 0;
            @(negedge clk);
            while (in_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check(1'b0, "accept_timeout", g, n, 0);
            @(posedge clk);
            #1;
        endtask

        // Apply per-cycle HOLD from hm (bit i = cycle k+1+i) until the frame ends.
        task automatic run_hold(input logic [15:0] hm);
            int i;
            hold = hm[0];
            i    = 1;
            forever begin
                @(negedge clk);
                if (busy !== 1'b1) break;
                if (i >= 80) begin
                    check(1'b0, "frame_timeout", g, i, 0);
                    break;
                end
                @(posedge clk);
                #1;
                hold = (i < 16) ? hm[i] : 1'b0;
                i++;
            end
            hold = 1'b0;
            @(posedge clk);
            #1;
        endtask

        task automatic send(input logic [W-1:0] d, input logic r, input logic [15:0] hm);
            in_valid = 1'b1;
            din      = d;
            dir      = r;
            wait_ready();
            in_valid = 1'b0;
            din      = W'($urandom);
            dir      = 1'($urandom);
            run_hold(hm);
        endtask

        // Driver: directed cases, back-to-back, randomized frames, then reset and tail.
        initial begin
            logic [W-1:0] d;
            logic [15:0]  hm;
            in_valid = 1'b0; din = '0; dir = 1'b0; hold = 1'b0;
            wait (started);
            @(posedge clk);
            #1;
            send(4'b1000, 1'b1, 16'h0000);
            send(4'b0011, 1'b0, 16'h0000);
            send(4'b1010, 1'b1, 16'h0006);
            in_valid = 1'b1; din = 4'b1010; dir = 1'b1;
            wait_ready();
            din = 4'b0101;
            @(negedge clk);
            while (in_ready !== 1'b1 && !done) @(negedge clk);
            check(done === 1'b1, "b2b_accept_in_done", g, int'(done), 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            din      = W'($urandom);
            run_hold(16'h0000);
            send(4'b1011, 1'b1, 16'h0000);
            send(4'b0110, 1'b1, 16'h0000);
            repeat (60) begin
                d  = W'($urandom);
                hm = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : 16'h0000;
                send(d, 1'($urandom), hm);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            at_bar = 1'b1;
            wait (go_rst);
            in_valid = 1'b1; din = 4'b1010; dir = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            din      = W'($urandom);
            wait (go_tail);
            send(4'b1100, 1'b0, 16'h0000);
            send(W'($urandom), 1'($urandom), 16'h0002);
            check(exp_q.size() == 0, "leftover_bits", g, exp_q.size(), 0);
            fin = 1'b1;
        end
    end

    // Top control: reset, barrier, mid-frame abort, summary.
    initial begin
        int n;
        clr_n   = 1'b1;
        started = 1'b0;
        go_rst  = 1'b0;
        go_tail = 1'b0;
        #1 clr_n = 1'b0;
        #21 clr_n = 1'b1;
        started = 1'b1;
        n = 0;
        while (!(g_lane[0].at_bar && g_lane[1].at_bar) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check(n < 20000, "barrier_timeout", 0, n, 0);
        @(posedge clk);
        #1;
        go_rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #3;
        clr_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        go_tail = 1'b1;
        n = 0;
        while (!(g_lane[0].fin && g_lane[1].fin) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check(n < 2000, "tail_timeout", 0, n, 0);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete at %0t", $time);
        $fatal(1);
    end

endmodule
